// File: rtl/mod_add_pkg.sv
// Shared definitions for the modular-adder operand issue block.
//   N_DEF      default operand/modulus width (matches downstream adder n)
//   CNT_W_DEF  default width of the issued-set counter
//   state_e    issue FSM states
package mod_add_pkg;

  localparam int N_DEF     = 7;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    UNCONF = 1'b0,
    CONF   = 1'b1
  } state_e;

endpackage

// File: rtl/mod_range_check.sv
// Unsigned range check of an operand pair against the modulus.
//   a, b  operands (N bits)
//   m     modulus (N bits)
//   err   high when a >= m or b >= m
module mod_range_check #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic         err
);

  assign err = (a >= m) || (b >= m);

endmodule

// File: rtl/mod_add_operand_issue.sv
// Operand issue stage for a modular adder: holds the modulus M and its
// complement K = 2^N - M, accepts operand pairs, flags out-of-range operands
// and presents a registered {a, b, K, err} set to the adder.
//   clk, rst                         clock, async active-high reset
//   cfg_valid/cfg_ready/cfg_m        modulus write handshake
//   cfg_err, configured              write status
//   in_valid/in_ready/in_a/in_b      operand pair input
//   out_valid/out_ready              output set handshake
//   out_a/out_b/out_k/out_err        registered set to adder a_v/b_v/k_v
//   issue_cnt                        sets consumed downstream (wraps)
//
// state  | meaning
// UNCONF | no legal modulus loaded; only cfg writes accepted
// CONF   | modulus loaded; operands flow, cfg accepted when output empty
module mod_add_operand_issue
  import mod_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     cfg_m,
  output logic             cfg_err,
  output logic             configured,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_a,
  output logic [N-1:0]     out_b,
  output logic [N-1:0]     out_k,
  output logic             out_err,
  output logic [CNT_W-1:0] issue_cnt
);

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d, k_q, k_d;
  logic [N-1:0]     out_a_q, out_a_d, out_b_q, out_b_d, out_k_q, out_k_d;
  logic             out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             range_err;
  logic             cfg_fire, in_fire, drain;

  mod_range_check #(.N(N)) u_range_check (
    .a   (in_a),
    .b   (in_b),
    .m   (m_q),
    .err (range_err)
  );

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    k_d         = k_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_k_d     = out_k_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    cfg_err_d   = cfg_err_q;
    issue_cnt_d = issue_cnt_q;

    // Modulus may only change while nothing computed with the old K is pending.
    cfg_ready = (state_q == UNCONF) ? 1'b1 : !out_valid_q;
    cfg_fire  = cfg_valid && cfg_ready;
    // cfg wins a same-cycle race so the operand sees the new modulus.
    in_ready  = (state_q == CONF) && (!out_valid_q || out_ready) && !cfg_fire;
    in_fire   = in_valid && in_ready;
    drain     = out_valid_q && out_ready;

    if (cfg_fire) begin
      if (|cfg_m[N-1:1]) begin
        m_d       = cfg_m;
        k_d       = ~cfg_m + {{(N-1){1'b0}}, 1'b1};
        cfg_err_d = 1'b0;
        state_d   = CONF;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (in_fire) begin
      out_a_d     = in_a;
      out_b_d     = in_b;
      out_k_d     = k_q;
      out_err_d   = range_err;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (drain) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNCONF;
      m_q         <= '0;
      k_q         <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_k_q     <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      k_q         <= k_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_k_q     <= out_k_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      cfg_err_q   <= cfg_err_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign configured = (state_q == CONF);
  assign cfg_err    = cfg_err_q;
  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_k      = out_k_q;
  assign out_err    = out_err_q;
  assign issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_mod_add_operand_issue.sv
module tb_mod_add_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_err, configured;
  logic [6:0]  cfg_m;
  logic        in_valid, in_ready;
  logic [6:0]  in_a, in_b;
  logic        out_valid, out_ready, out_err;
  logic [6:0]  out_a, out_b, out_k;
  logic [15:0] issue_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_add_operand_issue #(.N(7), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_m(cfg_m),
    .cfg_err(cfg_err), .configured(configured),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_k(out_k), .out_err(out_err),
    .issue_cnt(issue_cnt)
  );

  typedef struct {
    logic        cv;
    logic [6:0]  cm;
    logic        iv;
    logic [6:0]  a;
    logic [6:0]  b;
    logic        ordy;
    logic        e_irdy;
    logic        e_crdy;
    logic        e_ov;
    logic [6:0]  e_a;
    logic [6:0]  e_b;
    logic [6:0]  e_k;
    logic        e_err;
    logic        e_conf;
    logic        e_cerr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic cv, logic [6:0] cm, logic iv, logic [6:0] a,
                              logic [6:0] b, logic ordy, logic e_irdy, logic e_crdy,
                              logic e_ov, logic [6:0] e_a, logic [6:0] e_b,
                              logic [6:0] e_k, logic e_err, logic e_conf,
                              logic e_cerr, logic [15:0] e_cnt);
    vec_t v;
    v.cv = cv; v.cm = cm; v.iv = iv; v.a = a; v.b = b; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_crdy = e_crdy; v.e_ov = e_ov;
    v.e_a = e_a; v.e_b = e_b; v.e_k = e_k; v.e_err = e_err;
    v.e_conf = e_conf; v.e_cerr = e_cerr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [6:0] cm, input logic iv,
                       input logic [6:0] a, input logic [6:0] b, input logic ordy);
    cfg_valid = cv; cfg_m = cm; in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
  endtask

  initial begin
    //            cv  cm   iv  a    b   ordy irdy crdy ov  ea   eb   ek  eerr conf cerr cnt
    vecs[0]  = mk(1,  1,   1,  3,   4,  1,   0,   1,   0,  0,   0,   0,  0,   0,   1,   0);
    vecs[1]  = mk(1,  100, 0,  0,   0,  1,   0,   1,   0,  0,   0,   0,  0,   1,   0,   0);
    vecs[2]  = mk(0,  0,   1,  99,  0,  1,   1,   1,   1,  99,  0,   28, 0,   1,   0,   0);
    vecs[3]  = mk(0,  0,   1,  100, 5,  1,   1,   0,   1,  100, 5,   28, 1,   1,   0,   1);
    vecs[4]  = mk(1,  69,  0,  0,   0,  1,   1,   0,   0,  100, 5,   28, 1,   1,   0,   2);
    vecs[5]  = mk(1,  69,  1,  21,  37, 0,   0,   1,   0,  100, 5,   28, 1,   1,   0,   2);
    vecs[6]  = mk(0,  0,   1,  21,  37, 0,   1,   1,   1,  21,  37,  59, 0,   1,   0,   2);
    vecs[7]  = mk(0,  0,   1,  70,  5,  0,   0,   0,   1,  21,  37,  59, 0,   1,   0,   2);
    vecs[8]  = mk(1,  50,  1,  70,  5,  0,   0,   0,   1,  21,  37,  59, 0,   1,   0,   2);
    vecs[9]  = mk(1,  50,  1,  70,  5,  1,   1,   0,   1,  70,  5,   59, 1,   1,   0,   3);
    vecs[10] = mk(1,  50,  0,  0,   0,  1,   1,   0,   0,  70,  5,   59, 1,   1,   0,   4);
    vecs[11] = mk(1,  50,  0,  0,   0,  1,   0,   1,   0,  70,  5,   59, 1,   1,   0,   4);
    vecs[12] = mk(1,  1,   0,  0,   0,  1,   0,   1,   0,  70,  5,   59, 1,   1,   1,   4);
    vecs[13] = mk(0,  0,   1,  49,  68, 0,   1,   1,   1,  49,  68,  78, 1,   1,   1,   4);
    vecs[14] = mk(0,  0,   1,  49,  49, 1,   1,   0,   1,  49,  49,  78, 0,   1,   1,   5);
    vecs[15] = mk(1,  127, 0,  0,   0,  1,   1,   0,   0,  49,  49,  78, 0,   1,   1,   6);
    vecs[16] = mk(1,  127, 0,  0,   0,  1,   0,   1,   0,  49,  49,  78, 0,   1,   0,   6);
    vecs[17] = mk(0,  0,   1,  126, 127,0,   1,   1,   1,  126, 127, 1,  1,   1,   0,   6);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    chk("rst_out_valid", -1, int'(out_valid), 0);
    chk("rst_configured", -1, int'(configured), 0);
    chk("rst_cfg_ready", -1, int'(cfg_ready), 1);
    chk("rst_in_ready", -1, int'(in_ready), 0);
    chk("rst_issue_cnt", -1, int'(issue_cnt), 0);
    chk("rst_cfg_err", -1, int'(cfg_err), 0);
    chk("rst_out_k", -1, int'(out_k), 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].cv, vecs[i].cm, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy);
      #1;
      n_vec++;
      chk("in_ready", i, int'(in_ready), int'(vecs[i].e_irdy));
      chk("cfg_ready", i, int'(cfg_ready), int'(vecs[i].e_crdy));
      @(posedge clk);
      #1;
      chk("out_valid", i, int'(out_valid), int'(vecs[i].e_ov));
      chk("out_a", i, int'(out_a), int'(vecs[i].e_a));
      chk("out_b", i, int'(out_b), int'(vecs[i].e_b));
      chk("out_k", i, int'(out_k), int'(vecs[i].e_k));
      chk("out_err", i, int'(out_err), int'(vecs[i].e_err));
      chk("configured", i, int'(configured), int'(vecs[i].e_conf));
      chk("cfg_err", i, int'(cfg_err), int'(vecs[i].e_cerr));
      chk("issue_cnt", i, int'(issue_cnt), int'(vecs[i].e_cnt));
    end

    // Async reset between edges while a set is pending: dropped, not counted.
    drive(0, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    chk("midrst_out_valid", 100, int'(out_valid), 0);
    chk("midrst_issue_cnt", 100, int'(issue_cnt), 0);
    chk("midrst_configured", 100, int'(configured), 0);
    chk("midrst_out_k", 100, int'(out_k), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_issue_cnt", 101, int'(issue_cnt), 0);

    // Operands offered after reset without a modulus write must be refused.
    @(negedge clk);
    drive(0, 0, 1, 21, 37, 1);
    #1;
    n_vec++;
    chk("unconf_in_ready", 102, int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("unconf_out_valid", 102, int'(out_valid), 0);

    // Configure M=69 and wait (bounded) for the issued set.
    @(negedge clk);
    drive(1, 69, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 21, 37, 0);
    begin
      int waited;
      waited = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      while (!out_valid && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
      end
      n_vec++;
      chk("reissue_timeout", 103, int'(out_valid), 1);
      chk("reissue_wait", 103, waited, 0);
      chk("reissue_k", 103, int'(out_k), 59);
      chk("reissue_err", 103, int'(out_err), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_add_operand_issue.md
MOD_ADD_OPERAND_ISSUE -- requirements
Module: mod_add_operand_issue

Interface
REQ-001 The block SHALL have parameter N, default 7, giving the operand/modulus width in bits and matching the downstream adder's n.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the issued-transaction counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows (clock and reset first):
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  modulus write request.
- cfg_ready  output  1  modulus write accepted this cycle when high with cfg_valid.
- cfg_m  input  N  modulus M.
- cfg_err  output  1  last modulus write rejected (sticky until next accepted write).
- configured  output  1  a legal modulus is loaded.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  operand pair accepted when high with in_valid.
- in_a  input  N  operand a.
- in_b  input  N  operand b.
- out_valid  output  1  registered operand set presented to the adder.
- out_ready  input  1  downstream consumed the set.
- out_a  output  N  registered a, to adder a_v.
- out_b  output  N  registered b, to adder b_v.
- out_k  output  N  registered K = 2^N - M, to adder k_v.
- out_err  output  1  a >= M or b >= M for this set.
- issue_cnt  output  CNT_W  count of sets accepted by downstream.

Function
REQ-004 The block SHALL implement a two-state FSM, UNCONF and CONF.
REQ-005 In UNCONF, the block SHALL hold in_ready low and cfg_ready high.
REQ-006 The block SHALL accept a cfg write when cfg_valid && cfg_ready.
- M in 2..2^N-1: store M and K = 2^N - M (N-bit, computed as two's complement of M), clear cfg_err, go to CONF on the next edge.
- M = 0 or M = 1: reject the write, set cfg_err, keep the current state and the stored M/K.
REQ-007 In CONF, cfg_ready SHALL equal !out_valid, so the modulus changes only when the output register is empty.
REQ-008 The block SHALL drive in_ready = configured && (!out_valid || out_ready), giving single-register pass-through with full throughput.
REQ-009 On an in_valid && in_ready edge, the block SHALL load out_a = in_a, out_b = in_b, out_k = stored K, out_err = (in_a >= M) || (in_b >= M), and set out_valid.
- Latency is one cycle from acceptance to out_valid.
REQ-010 The block SHALL hold out_valid and all out_* stable while out_valid && !out_ready.
REQ-011 On an out_valid && out_ready edge with no new acceptance, the block SHALL clear out_valid.
REQ-012 On a simultaneous drain and accept, the block SHALL load the new set and keep out_valid high (no bubble).
REQ-013 The block SHALL increment issue_cnt on each out_valid && out_ready edge, wrapping modulo 2^CNT_W.
- Sets with out_err=1 are still issued and counted.
REQ-014 When cfg_valid and in_valid are both high in CONF with out_valid=0, the block SHALL give cfg priority: accept the cfg write and hold in_ready low that cycle.
REQ-015 All comparisons SHALL be unsigned N-bit, and no output SHALL depend combinationally on in_a or in_b.

Reset
REQ-016 On rst, the block SHALL immediately enter UNCONF and clear out_valid, out_a, out_b, out_k, out_err, cfg_err, configured, issue_cnt, and the stored M/K.
REQ-017 A reset asserted while out_valid is high SHALL discard the pending set, and no issue_cnt increment SHALL occur for it.
REQ-018 After reset deassertion, the first accepted operand SHALL require a prior legal cfg write.

Structure
REQ-019 The shared package mod_add_pkg SHALL hold the default N, default CNT_W, and the FSM state enum (UNCONF, CONF).
REQ-020 A sub-module mod_range_check (N-bit unsigned a<M, b<M comparator pair producing err) SHALL be instantiated once.
- K computation and the handshake stay inline.
REQ-021 The outputs out_a, out_b, and out_k SHALL connect directly to the downstream adder's a_v, b_v, and k_v.

Verification
REQ-022 Scenario: N=7, cfg_m=69, then in_a=21, in_b=37 -> next cycle out_valid=1, out_a=21, out_b=37, out_k=59, out_err=0.
REQ-023 Scenario: cfg_m=69, in_a=70, in_b=5 -> out_err=1, out_k=59, the set is issued, and issue_cnt increments on drain.
REQ-024 Scenario: out_ready=0 with two pairs offered -> the first is held stable, in_ready=0, and the second is accepted only on the cycle out_ready=1, with no bubble.
REQ-025 Scenario: cfg_m=1 after reset -> cfg_err=1, configured=0, in_ready=0; then cfg_m=100 -> configured=1, K=28.
REQ-026 Scenario: cfg_valid while out_valid=1 and out_ready=0 -> cfg_ready=0 and K unchanged until drain, after which cfg is accepted.
REQ-027 Scenario: rst pulsed mid-cycle with out_valid=1 -> out_valid=0 immediately, issue_cnt=0, state UNCONF.
